// File: rtl/uart_pkg.sv
// Shared state encoding and framing constants for the UART transmit path.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int UART_DATA_BITS  = 8;
  localparam int DEFAULT_CLK_DIV = 106;
endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO; push and pop take effect on the clock edge.
// full/empty derive from the occupancy register only, never from push/pop in the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two; level keeps full apart from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (do_pop && !do_push) level <= level - LVL_ONE;
    end
  end
endmodule

// File: rtl/uart_tx_driver.sv
// UART 8N1 serializer fed by a valid/ready byte stream through a small FIFO; start bit
// appears 2 clocks after an accept into an idle driver, in_ready drops only when the FIFO is full.
module uart_tx_driver
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [UART_DATA_BITS-1:0]     in_data,
  output logic                          in_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  state_t                    state;
  logic [15:0]               timer;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      line_active;
  logic                      bit_done;
  logic                      pop;

  assign bit_done = (timer == '0);
  assign pop      = !fifo_empty &&
                    ((state == IDLE) || (state == STOP && bit_done && bit_idx == LAST_STOP));
  assign in_ready = !fifo_full;
  // line_active covers the final registered stop-bit cycle after the FSM has already returned to IDLE.
  assign busy     = line_active || (state != IDLE) || (fifo_level != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && !fifo_full),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      ser_tx      <= 1'b1;
      line_active <= 1'b0;
    end else begin
      ser_tx      <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      line_active <= (state != IDLE);
      if (pop) begin
        shift   <= fifo_dout;
        timer   <= DIV_M1;
        bit_idx <= '0;
        state   <= START;
      end else begin
        case (state)
          IDLE: ;
          START: begin
            if (bit_done) begin
              timer <= DIV_M1;
              state <= DATA;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          DATA: begin
            if (bit_done) begin
              timer <= DIV_M1;
              shift <= shift >> 1;
              if (bit_idx == LAST_DATA) begin
                bit_idx <= '0;
                state   <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              timer <= timer - 16'd1;
            end
          end
          STOP: begin
            if (bit_done) begin
              timer <= DIV_M1;
              if (bit_idx == LAST_STOP) begin
                bit_idx <= '0;
                state   <= IDLE;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              timer <= timer - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_driver.sv
// Bench for uart_tx_driver: default-timing instance plus a CLK_DIV=4 / STOP_BITS=2 instance.
// A frame-level model predicts every byte and its start-bit cycle; a bit-centre decoder checks the line.
module tb_uart_tx_driver;
  localparam int FR0 = 10 * 106;
  localparam int FR1 = 11 * 4;

  typedef struct { logic [7:0] b; int s; } exp_t;
  typedef struct { int n; int lvl; logic rdy; logic bsy; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       r0, r1, tx0, tx1, busy0, busy1;
  logic [2:0] lvl0, lvl1;

  exp_t eq0[$];
  exp_t eq1[$];
  int   last0 = -100000;
  int   last1 = -100000;
  vec_t tbl[5];

  uart_tx_driver dut0 (
    .clk(clk), .reset(rst), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .ser_tx(tx0), .busy(busy0), .fifo_level(lvl0)
  );

  uart_tx_driver #(.CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .ser_tx(tx1), .busy(busy1), .fifo_level(lvl1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line(input int sel);
    return sel ? tx1 : tx0;
  endfunction

  function automatic logic rdy(input int sel);
    return sel ? r1 : r0;
  endfunction

  function automatic logic probe(input int sel, input bit use_busy);
    if (sel != 0) return use_busy ? busy1 : tx1;
    return use_busy ? busy0 : tx0;
  endfunction

  // Model: a byte accepted at edge A starts its frame at max(A+2, previous start + frame length).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        eq0.delete();
        eq1.delete();
        last0 = -100000;
        last1 = -100000;
      end else begin
        if (v0 && r0) begin
          last0 = (cyc + 3 > last0 + FR0) ? cyc + 3 : last0 + FR0;
          e.b = d0; e.s = last0;
          eq0.push_back(e);
        end
        if (v1 && r1) begin
          last1 = (cyc + 3 > last1 + FR1) ? cyc + 3 : last1 + FR1;
          e.b = d1; e.s = last1;
          eq1.push_back(e);
        end
      end
    end
  end

  task automatic wait_cyc(input int c, output bit ab);
    ab = 1'b0;
    while (cyc < c) begin
      @(negedge clk);
      if (rst) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  task automatic monitor(input int sel);
    int div, nstop, t0, qn;
    logic [7:0] b;
    bit ab, frame_ok;
    exp_t e;
    div   = sel ? 4 : 106;
    nstop = sel ? 2 : 1;
    forever begin
      @(negedge clk);
      if (rst || line(sel) !== 1'b0) continue;
      t0 = cyc;
      frame_ok = 1'b1;
      b = 8'h00;
      wait_cyc(t0 + div / 2, ab);
      if (!ab && line(sel) !== 1'b0) frame_ok = 1'b0;
      for (int k = 1; k <= 8 && !ab; k++) begin
        wait_cyc(t0 + k * div + div / 2, ab);
        b[k-1] = line(sel);
      end
      for (int c = t0 + 9 * div; c < t0 + (9 + nstop) * div && !ab; c++) begin
        wait_cyc(c, ab);
        if (!ab && line(sel) !== 1'b1) frame_ok = 1'b0;
      end
      if (ab) continue;
      qn = sel ? eq1.size() : eq0.size();
      if (qn == 0) begin
        chk(sel ? "mon1_pending" : "mon0_pending", qn, 1);
      end else begin
        if (sel != 0) e = eq1.pop_front();
        else          e = eq0.pop_front();
        chk(sel ? "mon1_byte" : "mon0_byte", b, e.b);
        chk(sel ? "mon1_start_cycle" : "mon0_start_cycle", t0, e.s);
        chk(sel ? "mon1_framing" : "mon0_framing", frame_ok, 1);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin v1 = v; d1 = d; end
    else begin v0 = v; d0 = d; end
  endtask

  task automatic push(input int sel, input logic [7:0] d, output int waited);
    waited = 0;
    drive(sel, 1'b1, d);
    while (rdy(sel) !== 1'b1 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (rdy(sel) !== 1'b1) chk("push_ready_timeout", rdy(sel), 1);
    else begin
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, d);
  endtask

  task automatic wait_for(input int sel, input bit use_busy, input logic val, input int max,
                          input string name, output int t);
    int n;
    n = 0;
    while (probe(sel, use_busy) !== val && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (probe(sel, use_busy) !== val) chk(name, probe(sel, use_busy), val);
    t = cyc;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc, t_fall, t_end, w, n_bad, gap;
    tbl[0] = '{1, 1, 1'b1, 1'b1};
    tbl[1] = '{2, 1, 1'b1, 1'b1};
    tbl[2] = '{3, 2, 1'b1, 1'b1};
    tbl[3] = '{4, 3, 1'b1, 1'b1};
    tbl[4] = '{5, 4, 1'b0, 1'b1};

    do_reset(3);
    chk("rst_ser_tx", tx0, 1);
    chk("rst_in_ready", r0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_fifo_level", lvl0, 0);
    n_bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || r0 !== 1'b1 || busy0 !== 1'b0 || lvl0 !== 3'd0 ||
          tx1 !== 1'b1 || r1 !== 1'b1 || busy1 !== 1'b0 || lvl1 !== 3'd0) n_bad++;
    end
    chk("idle_2000_violations", n_bad, 0);

    // Burst of n back-to-back bytes from idle: the first is popped one edge after its accept.
    for (int i = 0; i < 5; i++) begin
      do_reset(2);
      for (int j = 0; j < tbl[i].n; j++) push(0, 8'($urandom), w);
      chk($sformatf("tbl%0d_level", i), lvl0, tbl[i].lvl);
      chk($sformatf("tbl%0d_ready", i), r0, tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i), busy0, tbl[i].bsy);
    end
    do_reset(2);
    @(posedge clk); #1;

    push(0, 8'h55, w);
    acc = cyc;
    wait_for(0, 0, 1'b0, 20, "t2_start_timeout", t_fall);
    chk("t2_start_latency", t_fall - acc, 2);
    wait_for(0, 1, 1'b0, 1200, "t2_busy_timeout", t_end);
    chk("t2_busy_fall", t_end - t_fall, FR0);

    push(0, 8'h4F, w);
    push(0, 8'h4B, w);
    push(0, 8'h0A, w);
    wait_for(0, 0, 1'b0, 20, "t3_start_timeout", t_fall);
    wait_for(0, 1, 1'b0, 3500, "t3_busy_timeout", t_end);
    chk("t3_three_frames", t_end - t_fall, 3 * FR0);
    chk("t3_drained", eq0.size(), 0);

    for (int i = 0; i < 5; i++) push(0, 8'(8'h30 + i), w);
    chk("t4_level_full", lvl0, 4);
    chk("t4_ready_full", r0, 0);
    push(0, 8'h35, w);
    chk("t4_stall_cycles", w, 1057);
    chk("t4_level_refill", lvl0, 4);
    wait_for(0, 1, 1'b0, 7000, "t4_busy_timeout", t_end);
    chk("t4_drained", eq0.size(), 0);

    push(0, 8'hA5, w);
    push(0, 8'($urandom), w);
    push(0, 8'($urandom), w);
    wait_for(0, 0, 1'b0, 20, "t5_start_timeout", t_fall);
    repeat (500) @(posedge clk);
    #1;
    chk("t5_level_before", lvl0, 2);
    chk("t5_line_mid_frame", tx0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_ser_tx_after", tx0, 1);
    chk("t5_level_after", lvl0, 0);
    chk("t5_busy_after", busy0, 0);
    chk("t5_ready_after", r0, 1);
    rst = 1'b0;
    push(0, 8'h41, w);
    wait_for(0, 1, 1'b0, 1200, "t5_busy_timeout", t_end);
    chk("t5_drained", eq0.size(), 0);

    push(1, 8'h3C, w);
    acc = cyc;
    wait_for(1, 0, 1'b0, 20, "t6_start_timeout", t_fall);
    chk("t6_start_latency", t_fall - acc, 2);
    wait_for(1, 1, 1'b0, 100, "t6_busy_timeout", t_end);
    chk("t6_frame_length", t_end - t_fall, FR1);

    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      push(1, 8'($urandom), w);
    end
    wait_for(1, 1, 1'b0, 3000, "t6_busy_timeout", t_end);
    chk("t6_drained", eq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
